// File: rtl/axis_frame_pad.sv
// AXI4-Stream padder: extends frames shorter than MIN_FRAME_LENGTH lanes with zero lanes and moves tlast to the padded end.
// One output register stage; input ready is blocked while pad beats are generated and follows m_axis_tready combinationally.
module axis_frame_pad #(
  parameter int DATA_WIDTH       = 64,
  parameter bit KEEP_ENABLE      = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH       = (DATA_WIDTH + 7) / 8,
  parameter int MIN_FRAME_LENGTH = 60,
  parameter bit ID_ENABLE        = 1'b0,
  parameter int ID_WIDTH         = 8,
  parameter bit DEST_ENABLE      = 1'b0,
  parameter int DEST_WIDTH       = 8,
  parameter bit USER_ENABLE      = 1'b1,
  parameter int USER_WIDTH       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int LANES     = KEEP_ENABLE ? KEEP_WIDTH : 1;
  localparam int LANE_SIZE = DATA_WIDTH / LANES;
  localparam int CNT_W     = $clog2(MIN_FRAME_LENGTH + 1);

  if (LANE_SIZE * LANES != DATA_WIDTH) begin : g_width_check
    $error("axis_frame_pad: DATA_WIDTH does not divide evenly into byte lanes");
  end

  typedef enum logic {ST_PASS = 1'b0, ST_PAD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]      keep_q, keep_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic [LANES-1:0] keep_in;
  logic             load;
  logic             accept;
  int               n;
  int               cnt_i;
  int               rem;
  int               r;

  function automatic logic [LANES-1:0] lane_mask(input int k);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (i < k);
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] data_mask(input logic [LANES-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < LANES; i++) m[i*LANE_SIZE +: LANE_SIZE] = {LANE_SIZE{k[i]}};
    return m;
  endfunction

  assign keep_in       = KEEP_ENABLE ? s_axis_tkeep[LANES-1:0] : '1;
  assign load          = !vld_q || m_axis_tready;
  assign s_axis_tready = rst_n && (state_q == ST_PASS) && load;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    n = 0;
    for (int i = 0; i < LANES; i++) begin
      if (keep_in[i]) n = n + 1;
    end
  end

  assign cnt_i = int'(cnt_q);
  assign rem   = MIN_FRAME_LENGTH - cnt_i - n;
  assign r     = MIN_FRAME_LENGTH - cnt_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;
    keep_d  = keep_q;
    id_d    = id_q;
    dest_d  = dest_q;
    user_d  = user_q;
    if (load) begin
      vld_d = 1'b0;
      case (state_q)
        ST_PASS: begin
          if (accept) begin
            vld_d  = 1'b1;
            id_d   = ID_ENABLE   ? s_axis_tid   : '0;
            dest_d = DEST_ENABLE ? s_axis_tdest : '0;
            user_d = USER_ENABLE ? s_axis_tuser : '0;
            if (!s_axis_tlast || rem <= 0) begin
              data_d = s_axis_tdata;
              keep_d = keep_in;
              last_d = s_axis_tlast;
              if (s_axis_tlast) cnt_d = '0;
              else if (cnt_i + n >= MIN_FRAME_LENGTH) cnt_d = CNT_W'(MIN_FRAME_LENGTH);
              else cnt_d = CNT_W'(cnt_i + n);
            end else if (rem <= LANES - n) begin
              // Short tail fits in this beat: extend tkeep over zeroed lanes.
              data_d = s_axis_tdata & data_mask(lane_mask(n));
              keep_d = lane_mask(n + rem);
              last_d = 1'b1;
              cnt_d  = '0;
            end else begin
              data_d  = s_axis_tdata & data_mask(lane_mask(n));
              keep_d  = '1;
              last_d  = 1'b0;
              cnt_d   = CNT_W'(cnt_i + LANES);
              state_d = ST_PAD;
            end
          end
        end
        ST_PAD: begin
          // Sideband registers are left untouched so pad beats repeat the last input beat's tid/tdest/tuser.
          vld_d  = 1'b1;
          data_d = '0;
          if (r <= LANES) begin
            keep_d  = lane_mask(r);
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_PASS;
          end else begin
            keep_d = '1;
            last_d = 1'b0;
            cnt_d  = CNT_W'(cnt_i + LANES);
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PASS;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
    end
  end

  assign m_axis_tvalid = vld_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tid    = id_q;
  assign m_axis_tdest  = dest_q;
  assign m_axis_tuser  = user_q;

  if (KEEP_ENABLE) begin : g_keep
    assign m_axis_tkeep = keep_q;
  end else begin : g_no_keep
    assign m_axis_tkeep = '1;
  end

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tid, s_axis_tdest, s_axis_tkeep, keep_q};

endmodule
